// File: rtl/uart_bus_port_if.sv
// picorv32 native-bus slice seen by the UART responder: select, register address,
// write strobes and data in, one-shot ready and read data out.
interface uart_bus_port_if;
    logic        sel;
    logic        addr2;
    logic [3:0]  wstrb;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;

    modport master (
        output sel, addr2, wstrb, data_i,
        input  ready, data_o
    );

    modport slave (
        input  sel, addr2, wstrb, data_i,
        output ready, data_o
    );
endinterface

// File: rtl/uart_bus_port.sv
// Memory-mapped UART: DATA/STATUS registers on the native bus, an 8N1 transmitter
// behind one holding register, and a mid-bit-sampling receiver feeding an RX FIFO.
module uart_bus_port #(
    parameter int CLKS_PER_BIT = 234,
    parameter int RX_DEPTH     = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_bus_port_if.slave bus,
    input  logic           uart_rx,
    output logic           uart_tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       COUNT_MAX = 4'(RX_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RX_DEPTH - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Bus handshake
    logic             ready_q;
    logic             served_q, served_d;
    logic [31:0]      data_o_q, data_o_d;
    logic             is_write, data_wr, stall, fire;
    logic             hold_load, pop, sticky_clr;
    logic [31:0]      status_word, rx_head_word;

    // Transmit path
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_q, hold_d;
    logic [1:0]       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_take, tx_bit_end, tx_busy;

    // Receive path
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             push_req, frame_set;

    // RX FIFO and sticky status
    logic [7:0]       fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]       rx_count_q, rx_count_d;
    logic             fifo_full, push, overrun_set;
    logic             overrun_q, overrun_d, frame_err_q, frame_err_d;

    logic             unused_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_wdata = ^bus.data_i[31:8];

    assign is_write   = |bus.wstrb;
    assign data_wr    = !bus.addr2 && bus.wstrb[0];
    // A DATA write cannot complete while the holding register is still occupied.
    assign stall      = data_wr && hold_full_q;
    assign fire       = bus.sel && !served_q && !stall;
    assign served_d   = fire || (served_q && bus.sel);
    assign hold_load  = fire && data_wr;
    assign pop        = fire && !bus.addr2 && !is_write && (rx_count_q != 4'd0);
    assign sticky_clr = fire && bus.addr2 && is_write;

    assign tx_busy      = hold_full_q || (tx_state_q != TX_IDLE);
    assign rx_head_word = (rx_count_q != 4'd0) ? {23'd0, 1'b1, fifo_mem[rd_ptr_q]} : 32'd0;
    assign status_word  = {24'd0, rx_count_q, frame_err_q, overrun_q,
                           (rx_count_q != 4'd0), tx_busy};

    always_comb begin
        data_o_d = 32'd0;
        if (fire && !is_write) begin
            data_o_d = bus.addr2 ? status_word : rx_head_word;
        end
    end

    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (tx_take) begin
            hold_full_d = 1'b0;
        end
        if (hold_load) begin
            hold_full_d = 1'b1;
            hold_d      = bus.data_i[7:0];
        end
    end

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_take    = 1'b0;
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    tx_take    = 1'b1;
                    tx_shift_d = hold_q;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (hold_full_q) begin
                        tx_take    = 1'b1;
                        tx_shift_d = hold_q;
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    push_req   = rx_sync_q;
                    frame_set  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A pop on the same edge frees the slot, so a push then still fits.
    assign fifo_full   = (rx_count_q == COUNT_MAX);
    assign push        = push_req && (!fifo_full || pop);
    assign overrun_set = push_req && !push;

    assign wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign rx_count_d  = rx_count_q + 4'(push) - 4'(pop);
    assign overrun_d   = (overrun_q   && !sticky_clr) || overrun_set;
    assign frame_err_d = (frame_err_q && !sticky_clr) || frame_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q     <= 1'b0;
            served_q    <= 1'b0;
            data_o_q    <= 32'd0;
            hold_full_q <= 1'b0;
            hold_q      <= 8'd0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_line_q   <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rx_count_q  <= 4'd0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ready_q     <= fire;
            served_q    <= served_d;
            data_o_q    <= data_o_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_count_q  <= rx_count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.data_o = data_o_q;
    assign uart_tx    = tx_line_q;

endmodule

// File: tb/tb_uart_bus_port.sv
// Directed bench for uart_bus_port at 16 clocks per bit: register handshake, TX framing
// and stalling, RX FIFO, overrun/framing errors, glitch rejection and reset.
module tb_uart_bus_port;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int errors = 0;
    int checks = 0;

    logic rec_en = 1'b0;
    logic rec_q[$];

    uart_bus_port_if bus();

    uart_bus_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rec_en) rec_q.push_back(uart_tx);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus access; returns read data and the cycles from sel to ready (bounded).
    task automatic bus_access(input logic a2, input logic [3:0] ws, input logic [31:0] wd,
                              output logic [31:0] rd, output int waits);
        @(posedge clk); #1;
        bus.sel = 1'b1; bus.addr2 = a2; bus.wstrb = ws; bus.data_i = wd;
        waits = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (bus.ready !== 1'b1 && waits < 400);
        rd = bus.data_o;
        bus.sel = 1'b0; bus.wstrb = 4'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            uart_rx = fr[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        uart_rx = 1'b1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    initial begin
        logic [31:0] rd;
        int          w;
        int          bad;
        logic [7:0]  a5;
        logic [7:0]  tx3 [3];
        logic [7:0]  ov  [9];

        bus.sel = 1'b0; bus.addr2 = 1'b0; bus.wstrb = 4'd0; bus.data_i = 32'd0;
        a5 = 8'hA5;
        tx3[0] = 8'h11; tx3[1] = 8'h22; tx3[2] = 8'h33;
        ov[0] = 8'h01; ov[1] = 8'h80; ov[2] = 8'hFF; ov[3] = 8'h00; ov[4] = 8'h55;
        ov[5] = 8'hAA; ov[6] = 8'h0F; ov[7] = 8'hF0; ov[8] = 8'h99;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_data_o", bus.data_o, 32'd0);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        reset = 1'b0;
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("rst_status", rd, 32'h0);
        check("read_latency", w, 1);
        @(posedge clk); #1;
        check("ready_one_shot", {31'd0, bus.ready}, 32'd0);
        check("data_o_idle", bus.data_o, 32'd0);

        // Single TX frame
        bus_access(1'b0, 4'b0001, 32'hFFFF_FFA5, rd, w);
        check("tx_write_latency", w, 1);
        rec_q.delete();
        rec_en = 1'b1;
        repeat (170) @(posedge clk);
        #1;
        rec_en = 1'b0;
        check("tx_idle_before_start", {31'd0, rec_q[0]}, 32'd1);
        for (int b = 0; b < 10; b++) begin
            logic eb;
            eb = frame_bit(a5, b * CPB);
            check($sformatf("tx_a5_bit%0d", b), {30'd0, rec_q[1 + b*CPB], rec_q[CPB + b*CPB]},
                  {30'd0, eb, eb});
        end
        check("tx_after_frame", {31'd0, rec_q[1 + 10*CPB]}, 32'd1);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("tx_busy_clear", rd, 32'h0);

        // Back-to-back writes with a stalled third write
        bus_access(1'b0, 4'b0001, 32'h11, rd, w);
        rec_q.delete();
        rec_en = 1'b1;
        bus_access(1'b0, 4'b0001, 32'h22, rd, w);
        check("stall_w2_latency", w, 1);
        bus_access(1'b0, 4'b0001, 32'h33, rd, w);
        check("stall_w3_latency", w, 159);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("stall_tx_busy", rd, 32'h1);
        repeat (340) @(posedge clk);
        #1;
        rec_en = 1'b0;
        check("stall_idle_before", {31'd0, rec_q[0]}, 32'd1);
        for (int f = 0; f < 3; f++) begin
            bad = 0;
            for (int k = 0; k < 10*CPB; k++) begin
                if (rec_q[1 + f*10*CPB + k] !== frame_bit(tx3[f], k)) bad++;
            end
            check($sformatf("stall_frame%0d_bad_samples", f), bad, 0);
        end
        check("stall_idle_after", {31'd0, rec_q[1 + 30*CPB]}, 32'd1);

        // DATA write with wstrb[0] clear: completes, queues nothing
        bus_access(1'b0, 4'b0010, 32'h99, rd, w);
        check("nostrobe_latency", w, 1);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("nostrobe_status", rd, 32'h0);

        // Reset in the middle of a frame, while the line is low
        bus_access(1'b0, 4'b0001, 32'h5A, rd, w);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        reset = 1'b0;
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("midrst_status", rd, 32'h0);

        // RX into the FIFO and drain
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (4) @(posedge clk);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("rx_status_two", rd, 32'h22);
        bus_access(1'b0, 4'd0, 32'd0, rd, w);
        check("rx_read1", rd, 32'h13C);
        bus_access(1'b0, 4'd0, 32'd0, rd, w);
        check("rx_read2", rd, 32'h1C3);
        bus_access(1'b0, 4'd0, 32'd0, rd, w);
        check("rx_read_empty", rd, 32'h0);

        // Short glitch: rejected at the mid-start check
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (200) @(posedge clk);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("glitch_status", rd, 32'h0);

        // Overrun, then a framing error on a full FIFO, then clear
        for (int i = 0; i < 9; i++) send_byte(ov[i], 1'b1);
        repeat (4) @(posedge clk);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("overrun_status", rd, 32'h86);
        send_byte(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("frame_err_status", rd, 32'h8E);
        bus_access(1'b1, 4'b1111, 32'd0, rd, w);
        check("sticky_clear_latency", w, 1);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("sticky_cleared_status", rd, 32'h82);

        // Push on the same edge as a pop of a full FIFO
        fork
            send_byte(8'h77, 1'b1);
            begin
                logic [31:0] rd2;
                int          w2;
                repeat (154) @(posedge clk);
                bus_access(1'b0, 4'd0, 32'd0, rd2, w2);
                check("simul_pop_data", rd2, {23'd0, 1'b1, ov[0]});
            end
        join
        repeat (4) @(posedge clk);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("simul_status", rd, 32'h82);
        for (int i = 1; i < 8; i++) begin
            bus_access(1'b0, 4'd0, 32'd0, rd, w);
            check($sformatf("drain_%0d", i), rd, {23'd0, 1'b1, ov[i]});
        end
        bus_access(1'b0, 4'd0, 32'd0, rd, w);
        check("drain_last", rd, 32'h177);
        bus_access(1'b1, 4'd0, 32'd0, rd, w);
        check("final_status", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
